// File: rtl/anim_pkg.sv
// Shared types and default layout constants for the player animation sequencer.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JUMP = 2'd2,
    DEAD = 2'd3
  } anim_state_t;

  // Sprite sheet layout: one 28x92 frame is 2576 words; left-facing set follows the right set.
  localparam logic [20:0] FRAME_SIZE_DEF = 21'd2576;
  localparam logic [20:0] DIR_STRIDE_DEF = 21'd41216;

  localparam logic [20:0] IDLE_BASE_DEF  = 21'd0;
  localparam logic [20:0] RUN_BASE_DEF   = 21'd2576;
  localparam logic [20:0] JUMP_BASE_DEF  = 21'd18032;
  localparam logic [20:0] DEATH_BASE_DEF = 21'd28336;

endpackage

// File: rtl/anim_step_div.sv
// Counts frame_tick pulses and raises step on the last tick of each animation step.
module anim_step_div #(
  parameter logic [3:0] TICKS = 4'd6
) (
  input  logic frame_Clk,
  input  logic Reset,
  input  logic frame_tick,
  input  logic clear,
  output logic step
);

  localparam logic [3:0] LastCount = TICKS - 4'd1;

  logic [3:0] countQ;

  assign step = frame_tick && (countQ == LastCount);

  always_ff @(posedge frame_Clk) begin
    if (Reset || clear) begin
      countQ <= '0;
    end else if (step) begin
      countQ <= '0;
    end else if (frame_tick) begin
      countQ <= countQ + 4'd1;
    end
  end

endmodule

// File: rtl/player_anim_sequencer.sv
// Player sprite animation sequencer: picks the sprite frame offset once per video frame.
// Optional build macro PLAYER_ANIM_PINGPONG_EN makes the run cycle play forward then backward.
module player_anim_sequencer
  import anim_pkg::*;
#(
  parameter logic [20:0] FRAME_SIZE      = FRAME_SIZE_DEF,
  parameter logic [20:0] DIR_STRIDE      = DIR_STRIDE_DEF,
  parameter logic [3:0]  TICKS_PER_FRAME = 4'd6,
  parameter logic [2:0]  RUN_FRAMES      = 3'd6,
  parameter logic [2:0]  JUMP_FRAMES     = 3'd4,
  parameter logic [2:0]  DEATH_FRAMES    = 3'd5,
  parameter logic [20:0] IDLE_BASE       = IDLE_BASE_DEF,
  parameter logic [20:0] RUN_BASE        = RUN_BASE_DEF,
  parameter logic [20:0] JUMP_BASE       = JUMP_BASE_DEF,
  parameter logic [20:0] DEATH_BASE      = DEATH_BASE_DEF
) (
  input  logic        frame_Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        moving,
  input  logic        jumping,
  input  logic        hit,
  input  logic        respawn,
  input  logic        playerDirection,
  output logic [20:0] frameOffset,
  output logic [1:0]  animState,
  output logic [2:0]  frameIndex,
  output logic        deathDone
);

  localparam logic [2:0] RunLast   = RUN_FRAMES - 3'd1;
  localparam logic [2:0] JumpLast  = JUMP_FRAMES - 3'd1;
  localparam logic [2:0] DeathLast = DEATH_FRAMES - 3'd1;

  anim_state_t stateQ, stateD;
  logic [2:0]  idxQ, idxD;
  logic        dirQ, dirD;
  logic        deathDoneQ, deathDoneD;
  logic [20:0] offsetQ, offsetD, baseD;
  logic        step, clearDiv;
`ifdef PLAYER_ANIM_PINGPONG_EN
  logic        runDownQ, runDownD;
`endif

  assign clearDiv = frame_tick && (stateD != stateQ);

  anim_step_div #(
    .TICKS(TICKS_PER_FRAME)
  ) u_step_div (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .clear     (clearDiv),
    .step      (step)
  );

  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    dirD   = playerDirection;
`ifdef PLAYER_ANIM_PINGPONG_EN
    runDownD = runDownQ;
`endif

    case (stateQ)
      IDLE, RUN: begin
        if (hit)          stateD = DEAD;
        else if (jumping) stateD = JUMP;
        else              stateD = moving ? RUN : IDLE;
      end
      JUMP: begin
        if (hit)                             stateD = DEAD;
        else if (step && idxQ == JumpLast)   stateD = moving ? RUN : IDLE;
      end
      DEAD: begin
        // respawn outranks hit once the final death frame is showing
        if (deathDoneQ && respawn) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase

    if (stateD != stateQ) begin
      idxD = '0;
`ifdef PLAYER_ANIM_PINGPONG_EN
      runDownD = 1'b0;
`endif
    end else begin
      // Facing is frozen only while remaining in JUMP or DEAD; entry and exit take a fresh sample.
      if (stateQ == JUMP || stateQ == DEAD) dirD = dirQ;
      case (stateQ)
        RUN: begin
          if (step) begin
`ifdef PLAYER_ANIM_PINGPONG_EN
            if (RUN_FRAMES != 3'd1) begin
              if (!runDownQ) begin
                if (idxQ == RunLast) begin
                  idxD     = idxQ - 3'd1;
                  runDownD = (idxQ != 3'd1);
                end else begin
                  idxD = idxQ + 3'd1;
                end
              end else begin
                idxD = idxQ - 3'd1;
                if (idxQ == 3'd1) runDownD = 1'b0;
              end
            end
`else
            idxD = (idxQ == RunLast) ? 3'd0 : idxQ + 3'd1;
`endif
          end
        end
        JUMP:    if (step) idxD = idxQ + 3'd1;
        DEAD:    if (step && idxQ != DeathLast) idxD = idxQ + 3'd1;
        default: idxD = '0;
      endcase
    end
  end

  always_comb begin
    case (stateD)
      IDLE:    baseD = IDLE_BASE;
      RUN:     baseD = RUN_BASE;
      JUMP:    baseD = JUMP_BASE;
      DEAD:    baseD = DEATH_BASE;
      default: baseD = IDLE_BASE;
    endcase
    offsetD    = baseD + (dirD ? DIR_STRIDE : 21'd0) + 21'(idxD) * FRAME_SIZE;
    deathDoneD = (stateD == DEAD) && (idxD == DeathLast);
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      stateQ     <= IDLE;
      idxQ       <= '0;
      dirQ       <= 1'b0;
      offsetQ    <= IDLE_BASE;
      deathDoneQ <= 1'b0;
`ifdef PLAYER_ANIM_PINGPONG_EN
      runDownQ   <= 1'b0;
`endif
    end else if (frame_tick) begin
      stateQ     <= stateD;
      idxQ       <= idxD;
      dirQ       <= dirD;
      offsetQ    <= offsetD;
      deathDoneQ <= deathDoneD;
`ifdef PLAYER_ANIM_PINGPONG_EN
      runDownQ   <= runDownD;
`endif
    end
  end

  assign frameOffset = offsetQ;
  assign animState   = stateQ;
  assign frameIndex  = idxQ;
  assign deathDone   = deathDoneQ;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Self-checking bench for player_anim_sequencer: vector table, directed corner sequences, random run.
module tb_player_anim_sequencer;

  localparam int Tpf = 6;
  localparam int Rf  = 6;
  localparam int Jf  = 4;
  localparam int Df  = 5;
  localparam int Fs  = 2576;
  localparam int Ds  = 41216;

  logic        frame_Clk = 1'b0;
  logic        Reset = 1'b1, frame_tick = 1'b0, moving = 1'b0, jumping = 1'b0;
  logic        hit = 1'b0, respawn = 1'b0, playerDirection = 1'b0;
  logic [20:0] frameOffset;
  logic [1:0]  animState;
  logic [2:0]  frameIndex;
  logic        deathDone;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0..3, frame index, ticks since last step, facing, run step count
  int mState = 0, mIdx = 0, mCnt = 0, mDir = 0, mRunPos = 0;

  always #5 frame_Clk = ~frame_Clk;

  player_anim_sequencer dut (
    .frame_Clk      (frame_Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .moving         (moving),
    .jumping        (jumping),
    .hit            (hit),
    .respawn        (respawn),
    .playerDirection(playerDirection),
    .frameOffset    (frameOffset),
    .animState      (animState),
    .frameIndex     (frameIndex),
    .deathDone      (deathDone)
  );

  function automatic int mBase(input int s);
    case (s)
      1:       return 2576;
      2:       return 18032;
      3:       return 28336;
      default: return 0;
    endcase
  endfunction

  function automatic int mDone();
    return (mState == 3 && mIdx == Df - 1) ? 1 : 0;
  endfunction

  function automatic int mOffset();
    return mBase(mState) + mDir * Ds + mIdx * Fs;
  endfunction

  function automatic int runIdx(input int p);
    int period;
`ifdef PLAYER_ANIM_PINGPONG_EN
    if (Rf == 1) return 0;
    period = 2 * Rf - 2;
    return (p % period < Rf) ? p % period : period - (p % period);
`else
    period = Rf;
    return p % period;
`endif
  endfunction

  task automatic modelClock(input bit rst, tick, mv, jp, ht, rs, pd);
    int ns;
    bit stepNow;
    if (rst) begin
      mState = 0; mIdx = 0; mCnt = 0; mDir = 0; mRunPos = 0;
    end else if (tick) begin
      stepNow = (mCnt == Tpf - 1);
      case (mState)
        0, 1:    ns = ht ? 3 : jp ? 2 : mv ? 1 : 0;
        2:       ns = ht ? 3 : (stepNow && mIdx == Jf - 1) ? (mv ? 1 : 0) : 2;
        default: ns = (mDone() == 1 && rs) ? 0 : 3;
      endcase
      if (ns != mState) begin
        mState = ns; mIdx = 0; mCnt = 0; mRunPos = 0; mDir = int'(pd);
      end else begin
        if (mState <= 1) mDir = int'(pd);
        mCnt = stepNow ? 0 : mCnt + 1;
        if (stepNow) begin
          case (mState)
            1: begin mRunPos++; mIdx = runIdx(mRunPos); end
            2: mIdx++;
            3: if (mIdx < Df - 1) mIdx++;
            default: mIdx = 0;
          endcase
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, tick, mv, jp, ht, rs, pd);
    Reset = rst; frame_tick = tick; moving = mv; jumping = jp;
    hit = ht; respawn = rs; playerDirection = pd;
    @(posedge frame_Clk);
    modelClock(rst, tick, mv, jp, ht, rs, pd);
    #1;
    check("model_state",  int'(animState),   mState);
    check("model_index",  int'(frameIndex),  mIdx);
    check("model_offset", int'(frameOffset), mOffset());
    check("model_done",   int'(deathDone),   mDone());
  endtask

  typedef struct {
    bit rst, tick, mv, jp, ht, rs, pd;
    int st, idx, off, done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, tick, mv, jp, ht, rs, pd,
                              input int st, idx, off, done);
    vec_t v;
    v.rst = rst; v.tick = tick; v.mv = mv; v.jp = jp; v.ht = ht; v.rs = rs; v.pd = pd;
    v.st = st; v.idx = idx; v.off = off; v.done = done;
    return v;
  endfunction

  initial begin
    int runExp[6];
`ifdef PLAYER_ANIM_PINGPONG_EN
    runExp = '{1, 2, 3, 4, 5, 4};
`else
    runExp = '{1, 2, 3, 4, 5, 0};
`endif

    //            rst tck mv jp ht rs pd   st idx  off   done
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0,     0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 0,  2576, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 2576, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 1,  5152, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1,  5152, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 0,     0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1,  2, 0, 59248, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0,  3, 0, 28336, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1,  3, 0, 28336, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1,  0, 0,     0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1,  1, 0, 43792, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].tick, tbl[i].mv, tbl[i].jp, tbl[i].ht, tbl[i].rs, tbl[i].pd);
      check($sformatf("vec%0d_state", i),  int'(animState),   tbl[i].st);
      check($sformatf("vec%0d_index", i),  int'(frameIndex),  tbl[i].idx);
      check($sformatf("vec%0d_offset", i), int'(frameOffset), tbl[i].off);
      check($sformatf("vec%0d_done", i),   int'(deathDone),   tbl[i].done);
    end

    // Run cycle over 36 ticks
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 36; k++) begin
      cycle(0, 1, 1, 0, 0, 0, 0);
      if (k % 6 == 0) check($sformatf("run_step%0d_index", k / 6), int'(frameIndex), runExp[k / 6 - 1]);
    end

    // Left-facing jump, direction toggles ignored, lands in IDLE after 24 ticks
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 1);
    check("jump_entry_offset", int'(frameOffset), 59248);
    for (int k = 1; k <= 23; k++) begin
      cycle(0, 1, 0, 1'($urandom_range(0, 1)), 0, 0, 1'(k % 2));
      check("jump_hold_state", int'(animState), 2);
      check("jump_dir_held", int'(frameOffset), 59248 + (k / 6) * Fs);
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("jump_land_state", int'(animState), 0);
    check("jump_land_offset", int'(frameOffset), 0);

    // Hit during jump, early respawn ignored, respawn wins over hit once done
    cycle(0, 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0, 0);
    check("dead_entry_state", int'(animState), 3);
    for (int k = 1; k <= 24; k++) begin
      cycle(0, 1, 0, 0, 0, (k < 24) ? 1'b1 : 1'b0, 0);
      check("dead_early_respawn", int'(animState), 3);
      check("dead_done_timing", int'(deathDone), (k >= 24) ? 1 : 0);
    end
    check("dead_final_offset", int'(frameOffset), 28336 + 4 * Fs);
    cycle(0, 1, 0, 0, 1, 0, 1);
    check("dead_hold_done", int'(deathDone), 1);
    cycle(0, 1, 0, 0, 1, 1, 0);
    check("respawn_state", int'(animState), 0);
    check("respawn_offset", int'(frameOffset), 0);

    // Reset together with frame_tick mid-death
    cycle(0, 1, 0, 0, 1, 0, 1);
    for (int k = 0; k < 8; k++) cycle(0, 1, 0, 0, 1, 0, 1);
    cycle(1, 1, 1, 1, 1, 1, 1);
    check("rst_state", int'(animState), 0);
    check("rst_index", int'(frameIndex), 0);
    check("rst_offset", int'(frameOffset), 0);
    check("rst_done", int'(deathDone), 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) cycle(0, 1, 1, 0, 0, 0, 0);
    check("rst_div_cleared", int'(frameIndex), 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    check("rst_div_first_step", int'(frameIndex), 1);

    // Random traffic against the model
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
